l1_mem_arbiter: RTL and testbench
=================================

# l1_mem_arbiter

Two-port arbiter that shares the single external memory port between the instruction-side and data-side L1 caches. Each cache's memory interface (req/we/addr/wdata/rdata/ready) connects unchanged to one requester port. The arbiter grants whole refill bursts atomically, round-robin on burst boundaries, and forwards exactly one requester at a time to memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BURST_LEN, 4, read beats per refill burst (= cache words per block); power of 2, ≥1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  requester memory request (m0 = I-cache, m1 = D-cache)
- m0_we / m1_we  in  1  requester write enable
- m0_addr / m1_addr  in  ADDR_WIDTH  requester address
- m0_wdata / m1_wdata  in  DATA_WIDTH  requester write data
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, both driven from mem_rdata
- m0_ready / m1_ready  out  1  beat complete for that requester
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_rdata  in  DATA_WIDTH  read data from memory
- mem_ready  in  1  memory beat complete
- gnt  out  2  one-hot current owner (bit0 = m0); 2'b00 when idle

## Operation
- States: IDLE, BUSY. Registers: state, owner (1 bit), last (1 bit, last granted port), beat_cnt ($clog2(BURST_LEN) bits, min 1).
- Reset: state=IDLE, owner=0, last=1, beat_cnt=0, so m0 wins the first contested arbitration.
- IDLE: mem_req=0, m*_ready=0, gnt=00. If exactly one mX_req is high, that port wins. If both are high, the port != last wins. On a win, next state is BUSY, owner=winner, beat_cnt=0.
- BUSY: mem_req/we/addr/wdata = owner's inputs (combinational mux). owner_ready = mem_ready. Non-owner ready = 0. gnt = onehot(owner).
- Beat accepted = owner_req && mem_ready. On acceptance:
  - Write (owner_we=1): burst ends after that single beat.
  - Read: beat_cnt++; burst ends when beat_cnt == BURST_LEN-1.
- Burst end: next state IDLE, last=owner, beat_cnt=0.
- Abort: owner_req low while BUSY. Next state IDLE, last=owner. No memory beat is issued that cycle because mem_req follows owner_req.
- The non-owner's request is held off, not dropped. The requester keeps req high; the arbiter takes no queueing action.
- Requester addr/we must stay stable except for the incrementing word address during a burst. The arbiter does not check this.
- mem_rdata is broadcast; only the ready strobe is steered.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE is forwarded to memory from the next cycle.
- mem_ready → mX_ready: combinational, same cycle.
- With a zero-wait memory (mem_ready=1 whenever mem_req=1), a read burst occupies 1 IDLE + BURST_LEN BUSY cycles. A write occupies 1 + 1.
- Back-to-back contention: exactly one IDLE cycle between consecutive bursts. Ownership alternates m0, m1, m0, …
- Memory wait states (mem_ready=0) hold BUSY with beat_cnt unchanged, indefinitely.
- beat_cnt never wraps inside a burst. It is cleared on every return to IDLE.
- rst asserted mid-burst: state=IDLE at the next edge; mem_req=0 and gnt=00 from that edge on.
- All outputs after reset: mem_req=0, mem_we=0, m0_ready=m1_ready=0, gnt=00. mem_addr/mem_wdata/m*_rdata are don't-care but non-X: mux defaults to m0 and the rdata broadcast.

## Structure
- Shared package: state enum (IDLE, BUSY) and a port-index typedef. Package name: l1_mem_pkg.
- No sub-module required. The arbitration pick (2-way round-robin from req vector and last) may be a function in the package for reuse by a future N-port version.

## Test plan
- Single read, m0 only, zero-wait memory, addr 0x100: mem_req rises one cycle after m0_req. mem_addr follows 0x100, 0x104, 0x108, 0x10C. m0_ready high for 4 cycles. gnt=01 for 4 cycles, then 00. m1_ready stays 0.
- Both request reads in the same cycle after reset: m0 bursts first (gnt=01 ×4), one IDLE cycle, then m1 (gnt=10 ×4). Next simultaneous contest: m0 wins.
- m1 single write, addr 0x40, wdata 0xDEADBEEF, memory with 2 wait cycles: mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for 3 BUSY cycles. m1_ready pulses once on the third. Then IDLE.
- Read burst with mem_ready toggling 1,0,1,0,…: exactly 4 accepted beats over 7 BUSY cycles. beat_cnt holds on wait cycles. m0_ready never asserts while m1 owns.
- m0 drops req after 2 beats: IDLE next cycle. Pending m1 is granted on the following cycle with beat_cnt=0 and completes a full 4-beat burst.
- rst pulsed during beat 2 of an m1 burst: gnt=00 and mem_req=0 after the edge. After rst release, a contested arbitration grants m0 first.

Source files
------------

// File: rtl/l1_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_mem_pkg
// Purpose  : Shared types and round-robin pick for the L1 memory arbiter.
// Revision : 1.0
// ============================================================================
package l1_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef logic [0:0] port_idx_t;

  localparam int unsigned NUM_PORTS = 2;

  // Two-way round robin: a lone requester wins; a tie goes to the port that was not served last.
  function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_idx_t last);
    if (req == 2'b11) begin
      return ~last;
    end else if (req[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l1_mem_arbiter
// Purpose  : Shares one memory port between I-cache (m0) and D-cache (m1),
//            granting whole bursts atomically, round-robin between bursts.
// Revision : 1.0
// ============================================================================
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            gnt
);

  localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_e       state_q, state_d;
  port_idx_t        owner_q, owner_d;
  port_idx_t        last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic busy;
  logic owner_req;
  logic owner_we;

  assign busy      = (state_q == BUSY);
  assign owner_req = owner_q[0] ? m1_req : m0_req;
  assign owner_we  = owner_q[0] ? m1_we  : m0_we;

  // Address/data mux is left open in IDLE; owner resets to m0 so it stays defined.
  assign mem_req   = busy & owner_req;
  assign mem_we    = busy & owner_we;
  assign mem_addr  = owner_q[0] ? m1_addr  : m0_addr;
  assign mem_wdata = owner_q[0] ? m1_wdata : m0_wdata;

  assign m0_ready  = busy & ~owner_q[0] & mem_ready;
  assign m1_ready  = busy &  owner_q[0] & mem_ready;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  assign gnt       = busy ? (owner_q[0] ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d    = BUSY;
          owner_d    = rr_pick({m1_req, m0_req}, last_q);
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        // A dropped request aborts the burst; writes are always single-beat.
        if (!owner_req || (mem_ready && (owner_we || beat_cnt_q == LAST_BEAT))) begin
          state_d    = IDLE;
          last_d     = owner_q;
          beat_cnt_d = '0;
        end else if (mem_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_mem_arbiter
// Purpose  : Scoreboard bench for l1_mem_arbiter with directed burst scenarios.
// Revision : 1.0
// ============================================================================
module tb_l1_mem_arbiter;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          at;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;

  int          cyc = 0;
  int          t0 = 0;
  logic [15:0] rdy_pat = 16'hFFFF;
  int          rem0 = 0;
  int          rem1 = 0;
  logic        fire0 = 1'b0;
  logic        fire1 = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       sb[$];

  l1_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BURST_LEN (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .gnt      (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns a recognisable function of the address it is given.
  assign mem_rdata = mem_addr ^ RD_KEY;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string name);
    check({name, "_gnt"},      {62'd0, gnt},  64'd0);
    check({name, "_mem_req"},  {63'd0, mem_req},  64'd0);
    check({name, "_mem_we"},   {63'd0, mem_we},   64'd0);
    check({name, "_m0_ready"}, {63'd0, m0_ready}, 64'd0);
    check({name, "_m1_ready"}, {63'd0, m1_ready}, 64'd0);
  endtask

  // One clock: requesters advance on beats that completed at this edge, memory applies its ready pattern.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    if (fire0) begin
      m0_addr = m0_addr + 32'd4;
      rem0--;
      if (rem0 == 0) m0_req = 1'b0;
    end
    if (fire1) begin
      m1_addr = m1_addr + 32'd4;
      rem1--;
      if (rem1 == 0) m1_req = 1'b0;
    end
    idx = cyc - t0;
    mem_ready = (idx >= 0 && idx < 16) ? rdy_pat[idx] : 1'b1;
  endtask

  task automatic begin_test(input logic [15:0] pat);
    t0        = cyc;
    rdy_pat   = pat;
    mem_ready = pat[0];
  endtask

  task automatic start_req(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input int n);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; rem0 = n;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; rem1 = n;
    end
  endtask

  task automatic push_burst(input logic [1:0] g, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input int n, input int first, input int stride);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.gnt   = g;
      b.we    = we;
      b.addr  = addr + 32'(4 * i);
      b.wdata = wd;
      b.at    = t0 + first + stride * i;
      sb.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
    #2;
    chk_idle(name);
  endtask

  // Monitor: every presented memory request is compared to the scoreboard head; accepted beats pop it.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      fire0 = (m0_req === 1'b1) && (m0_ready === 1'b1);
      fire1 = (m1_req === 1'b1) && (m1_ready === 1'b1);
      if (mem_req === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_mem_req", {63'd0, mem_req}, 64'd0);
        end else begin
          e = sb[0];
          check("gnt",       {62'd0, gnt},       {62'd0, e.gnt});
          check("mem_we",    {63'd0, mem_we},    {63'd0, e.we});
          check("mem_addr",  {32'd0, mem_addr},  {32'd0, e.addr});
          check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
          check("m0_ready",  {63'd0, m0_ready},  {63'd0, mem_ready & e.gnt[0]});
          check("m1_ready",  {63'd0, m1_ready},  {63'd0, mem_ready & e.gnt[1]});
          if (mem_ready === 1'b1) begin
            check("beat_cycle", 64'(cyc), 64'(e.at));
            check("m0_rdata",   {32'd0, m0_rdata}, {32'd0, e.addr ^ RD_KEY});
            check("m1_rdata",   {32'd0, m1_rdata}, {32'd0, e.addr ^ RD_KEY});
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    chk_idle("reset");

    // m0 alone, zero-wait read burst; request cycle itself shows nothing on memory.
    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b0, 32'h100, 32'h0, 4);
    push_burst(2'b01, 1'b0, 32'h100, 32'h0, 4, 1, 1);
    #2;
    chk_idle("t1_arb_cycle");
    wait_drain("t1");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk_idle("t2_reset");

    // Simultaneous reads after reset: m0 first, one idle cycle, then m1.
    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b0, 32'h200, 32'h0, 4);
    start_req(1, 1'b0, 32'h300, 32'h0, 4);
    push_burst(2'b01, 1'b0, 32'h200, 32'h0, 4, 1, 1);
    push_burst(2'b10, 1'b0, 32'h300, 32'h0, 4, 6, 1);
    repeat (5) tick();
    #2;
    chk_idle("t2_gap");
    wait_drain("t2");

    // Next contest goes to m0 again.
    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b1, 32'h20, 32'hA0A0_A0A0, 1);
    start_req(1, 1'b1, 32'h24, 32'hB1B1_B1B1, 1);
    push_burst(2'b01, 1'b1, 32'h20, 32'hA0A0_A0A0, 1, 1, 1);
    push_burst(2'b10, 1'b1, 32'h24, 32'hB1B1_B1B1, 1, 3, 1);
    wait_drain("t2b");

    // m1 write with two wait cycles.
    tick();
    begin_test(16'hFFF9);
    start_req(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1);
    push_burst(2'b10, 1'b1, 32'h40, 32'hDEAD_BEEF, 1, 3, 1);
    wait_drain("t3");

    // m1 read with ready toggling every other cycle.
    tick();
    begin_test(16'hAAAA);
    start_req(1, 1'b0, 32'h80, 32'h0, 4);
    push_burst(2'b10, 1'b0, 32'h80, 32'h0, 4, 1, 2);
    wait_drain("t4");

    // m0 aborts after two beats; pending m1 then gets a full burst.
    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b0, 32'h500, 32'h0, 2);
    push_burst(2'b01, 1'b0, 32'h500, 32'h0, 2, 1, 1);
    repeat (2) tick();
    start_req(1, 1'b0, 32'h600, 32'h0, 4);
    push_burst(2'b10, 1'b0, 32'h600, 32'h0, 4, 5, 1);
    repeat (2) tick();
    #2;
    chk_idle("t5_abort");
    wait_drain("t5");

    // m0 write leaves last=m0 so the reset below is what restores m0 priority.
    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b1, 32'h10, 32'h1234_5678, 1);
    push_burst(2'b01, 1'b1, 32'h10, 32'h1234_5678, 1, 1, 1);
    wait_drain("t6");

    // Reset during the third beat of an m1 burst.
    tick();
    begin_test(16'hFFFF);
    start_req(1, 1'b0, 32'h700, 32'h0, 4);
    push_burst(2'b10, 1'b0, 32'h700, 32'h0, 3, 1, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m1_req = 1'b0;
    rem1 = 0;
    #2;
    chk_idle("t7_rst");
    check("t7_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();

    tick();
    begin_test(16'hFFFF);
    start_req(0, 1'b1, 32'h30, 32'hC0C0_C0C0, 1);
    start_req(1, 1'b1, 32'h34, 32'hD1D1_D1D1, 1);
    push_burst(2'b01, 1'b1, 32'h30, 32'hC0C0_C0C0, 1, 1, 1);
    push_burst(2'b10, 1'b1, 32'h34, 32'hD1D1_D1D1, 1, 3, 1);
    wait_drain("t7b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
